multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RISC-V core: decodes the latched instruction fields, sequences the shared ALU, memory and register file through fetch/decode/execute/memory/writeback steps, and resolves conditional branches internally from the ALU flags. It drives every datapath select and enable each cycle. It replaces the standalone combinational branch decision with a state-qualified one.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/alu_decoder.sv | 25 ++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RISC-V control FSM
// State enum, opcode/func3 constants, datapath select encodings and immediate-format lookup.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle
// master is the controller side; slave is the datapath side.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       is_zero;
  logic       is_neg;
  logic       is_carry;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [2:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, func3, func7_5, is_zero, is_neg, is_carry,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, illegal
  );

  modport slave (
    output opcode, func3, func7_5, is_zero, is_neg, is_carry,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - ALU operation select from func3/func7_5
// func7_5 only selects subtract for R-type; for I-type it is an immediate bit.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       r_type,
  input  logic [2:0] func3,
  input  logic       func7_5,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (func3)
      3'b000:  alu_ctrl = (r_type && func7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_ctrl = ALU_SLT;
      3'b011:  alu_ctrl = ALU_SLTU;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V control FSM with internal branch resolution
// Define UNSIGNED_BRANCH_EN to resolve bltu/bgeu from is_carry; otherwise they are never taken.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t     state, state_next;
  logic       taken;
  logic [2:0] dec_alu_ctrl;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_ctrl;
  logic       instr_done, illegal;

  alu_decoder u_alu_decoder (
    .r_type  (bus.opcode == OP_RTYPE),
    .func3   (bus.func3),
    .func7_5 (bus.func7_5),
    .alu_ctrl(dec_alu_ctrl)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.func3)
      F3_BEQ:  taken = bus.is_zero;
      F3_BNE:  taken = ~bus.is_zero;
      F3_BLT:  taken = bus.is_neg;
      F3_BGE:  taken = ~bus.is_neg;
`ifdef UNSIGNED_BRANCH_EN
      F3_BLTU: taken = ~bus.is_carry;
      F3_BGEU: taken = bus.is_carry;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef UNSIGNED_BRANCH_EN
  logic unused_carry;
  assign unused_carry = bus.is_carry;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Outputs are forced inactive while rst is high, even though state already reads FETCH.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      imm_src = imm_sel(bus.opcode);
      case (state)
        FETCH: begin
          ir_write   = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
        DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          case (bus.opcode)
            OP_LOAD, OP_STORE: state_next = MEM_ADDR;
            OP_RTYPE:          state_next = EXEC_R;
            OP_ITYPE:          state_next = EXEC_I;
            OP_BRANCH:         state_next = BRANCH;
            OP_JAL:            state_next = JAL;
            OP_LUI:            state_next = LUI;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_next = FETCH;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          state_next = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          adr_src    = 1'b1;
          state_next = MEM_WB;
        end
        MEM_WB: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        MEM_WRITE: begin
          adr_src    = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        EXEC_R, EXEC_I: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = (state == EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
          alu_ctrl   = dec_alu_ctrl;
          state_next = ALU_WB;
        end
        ALU_WB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        BRANCH: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_ctrl   = ALU_SUB;
          result_src = RES_ALUOUT;
          pc_write   = taken;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        JAL: begin
          // ALUOut still holds the target from DECODE while old PC + 4 is computed into it.
          alu_src_a  = SRC_A_OLDPC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALUOUT;
          pc_write   = 1'b1;
          state_next = ALU_WB;
        end
        LUI: begin
          result_src = RES_IMM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.imm_src    = imm_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
// Output vector: {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, illegal}.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] pk(input logic pw, input logic as_, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [2:0] alu,
                                     input logic dn, input logic il);
    return {pw, as_, mw, irw, rw, rs, sa, sb, imm, alu, dn, il};
  endfunction

  function automatic logic [18:0] ov();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl,
            bus.instr_done, bus.illegal};
  endfunction

  function automatic logic [18:0] v_fetch(input logic [2:0] imm);
    return pk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [18:0] v_decode(input logic [2:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [18:0] v_alu_wb(input logic [2:0] imm);
    return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.opcode  = op;
    bus.func3   = f3;
    bus.func7_5 = f7;
  endtask

  task automatic set_flags(input logic z, input logic n, input logic c);
    bus.is_zero  = z;
    bus.is_neg   = n;
    bus.is_carry = c;
  endtask

  task automatic test_reset();
    logic [18:0] e [4];
    set_instr(7'b0110011, 3'b000, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (ov() !== 19'd0) begin
        bad++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, ov(), 19'd0);
      end
    end
    e[0] = v_fetch(3'b000);
    e[1] = v_decode(3'b000);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL reset_first_run cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      #1;
      total++;
      if (ov() !== 19'd0) begin
        bad++; $display("FAIL reset_mid_exec cyc%0d: got %b want %b", i, ov(), 19'd0);
      end
    end
    e[3] = v_alu_wb(3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL reset_recover cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [18:0] e [4];
    for (int k = 0; k < 2; k++) begin
      e[0] = v_fetch(3'b000);
      e[1] = v_decode(3'b000);
      e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, (k == 0) ? 3'b000 : 3'b001, 0, 0);
      e[3] = v_alu_wb(3'b000);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) set_instr(7'b0110011, 3'b000, k[0]);
        #1;
        total++;
        if (ov() !== e[i]) begin
          bad++; $display("FAIL add_sub k%0d cyc%0d: got %b want %b", k, i, ov(), e[i]);
        end
      end
    end
  endtask

  task automatic test_alu_ops();
    // {R-type?, func3, func7_5, expected alu_ctrl}
    logic [7:0]  tbl [5];
    logic [18:0] e [4];
    tbl[0] = {1'b0, 3'b000, 1'b1, 3'b000};
    tbl[1] = {1'b0, 3'b100, 1'b0, 3'b100};
    tbl[2] = {1'b1, 3'b111, 1'b0, 3'b010};
    tbl[3] = {1'b1, 3'b010, 1'b0, 3'b101};
    tbl[4] = {1'b0, 3'b110, 1'b0, 3'b011};
    for (int k = 0; k < 5; k++) begin
      e[0] = v_fetch(3'b000);
      e[1] = v_decode(3'b000);
      e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, tbl[k][7] ? 2'b00 : 2'b01, 3'b000, tbl[k][2:0], 0, 0);
      e[3] = v_alu_wb(3'b000);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) set_instr(tbl[k][7] ? 7'b0110011 : 7'b0010011, tbl[k][6:4], tbl[k][3]);
        #1;
        total++;
        if (ov() !== e[i]) begin
          bad++; $display("FAIL alu_op k%0d cyc%0d: got %b want %b", k, i, ov(), e[i]);
        end
      end
    end
  endtask

  task automatic test_load_store();
    logic [18:0] e [5];
    e[0] = v_fetch(3'b000);
    e[1] = v_decode(3'b000);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    e[3] = pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
    e[4] = pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(7'b0000011, 3'b010, 1'b0);
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL lw cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
    e[0] = v_fetch(3'b001);
    e[1] = v_decode(3'b001);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0, 0);
    e[3] = pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(7'b0100011, 3'b010, 1'b0);
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL sw cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
  endtask

  task automatic test_branch();
    // {func3, is_zero, is_neg, is_carry, taken}
    logic [6:0]  tbl [8];
    logic [18:0] e [3];
    logic        ub;
`ifdef UNSIGNED_BRANCH_EN
    ub = 1'b1;
`else
    ub = 1'b0;
`endif
    tbl[0] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = {3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = {3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = {3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = {3'b110, 1'b0, 1'b0, 1'b0, ub};
    tbl[7] = {3'b111, 1'b0, 1'b0, 1'b1, ub};
    for (int k = 0; k < 8; k++) begin
      e[0] = v_fetch(3'b010);
      e[1] = v_decode(3'b010);
      e[2] = pk(tbl[k][0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b001, 1, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (i == 0) begin
          set_instr(7'b1100011, tbl[k][6:4], 1'b0);
          set_flags(tbl[k][3], tbl[k][2], tbl[k][1]);
        end
        #1;
        total++;
        if (ov() !== e[i]) begin
          bad++; $display("FAIL branch k%0d cyc%0d: got %b want %b", k, i, ov(), e[i]);
        end
      end
    end
  endtask

  task automatic test_branch_comb();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        set_instr(7'b1100011, 3'b000, 1'b0);
        set_flags(1'b0, 1'b0, 1'b0);
      end
      #1;
    end
    total++;
    if (bus.pc_write !== 1'b0) begin
      bad++; $display("FAIL beq_flag_low: got %b want %b", bus.pc_write, 1'b0);
    end
    bus.is_zero = 1'b1;
    #1;
    total++;
    if (bus.pc_write !== 1'b1) begin
      bad++; $display("FAIL beq_flag_rise: got %b want %b", bus.pc_write, 1'b1);
    end
  endtask

  task automatic test_jal_lui();
    logic [18:0] e [4];
    e[0] = v_fetch(3'b011);
    e[1] = v_decode(3'b011);
    e[2] = pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 3'b000, 0, 0);
    e[3] = v_alu_wb(3'b011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(7'b1101111, 3'b000, 1'b0);
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL jal cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
    e[0] = v_fetch(3'b100);
    e[1] = v_decode(3'b100);
    e[2] = pk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(7'b0110111, 3'b000, 1'b0);
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL lui cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e [3];
    e[0] = v_fetch(3'b000);
    e[1] = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1, 1);
    e[2] = v_fetch(3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) set_instr(7'b1111111, 3'b000, 1'b0);
      #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL illegal cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
    // Finish the fetch started above with a full add so later tests stay aligned.
    e[0] = v_decode(3'b000);
    e[1] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0);
    e[2] = v_alu_wb(3'b000);
    set_instr(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (ov() !== e[i]) begin
        bad++; $display("FAIL after_illegal cyc%0d: got %b want %b", i, ov(), e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_branch_comb();
    test_jal_lui();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
